// File: rtl/pipelined_cla_addsub_if.sv
// Valid/ready operand and result bundle for the pipelined carry-lookahead adder/subtractor.
// The master drives operands and out_ready; the slave (the adder) returns the result and flags.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIn;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, carryIn, sub, out_ready,
    input  in_ready, out_valid, sum, carryOut, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, carryIn, sub, out_ready,
    output in_ready, out_valid, sum, carryOut, overflow, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// group carry registered between stages, single global advance for full backpressure.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_cla_addsub_if.slave  bus
);

  localparam int NSTAGE = WIDTH / BLOCK;

  generate
    if ((BLOCK < 1) || (BLOCK > 8) || ((WIDTH % BLOCK) != 0)) begin : g_bad_params
      $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and BLOCK must be 1..8");
    end
  endgenerate

  // Full lookahead expansion: each carry is a sum of products of g/p and cin, no ripple through c[i].
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] p,
                                               input logic [BLOCK-1:0] g,
                                               input logic             cin);
    logic [BLOCK:0] c;
    logic           term;
    c    = {(BLOCK+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) begin
        term = term & p[j];
      end
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p[m];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Resolves group k of the operands; returns {overflow_of_group, carry_out, updated_sum}.
  function automatic logic [WIDTH+1:0] group_add(input logic [WIDTH-1:0] ga,
                                                 input logic [WIDTH-1:0] gbx,
                                                 input logic [WIDTH-1:0] gs,
                                                 input logic             gcin,
                                                 input int               k);
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   cy;
    logic [WIDTH-1:0] s;
    p  = ga[k*BLOCK +: BLOCK] ^ gbx[k*BLOCK +: BLOCK];
    g  = ga[k*BLOCK +: BLOCK] & gbx[k*BLOCK +: BLOCK];
    cy = lookahead(p, g, gcin);
    s  = gs;
    s[k*BLOCK +: BLOCK] = p ^ cy[BLOCK-1:0];
    return {cy[BLOCK] ^ cy[BLOCK-1], cy[BLOCK], s};
  endfunction

  logic [WIDTH-1:0]  a_r  [NSTAGE];
  logic [WIDTH-1:0]  bx_r [NSTAGE];
  logic [WIDTH-1:0]  s_r  [NSTAGE];
  logic [NSTAGE-1:0] c_r;
  logic [NSTAGE-1:0] v_r;
  logic              ovf_r;
  logic              zero_r;

  logic [WIDTH-1:0]  a_s  [NSTAGE];
  logic [WIDTH-1:0]  bx_s [NSTAGE];
  logic [WIDTH-1:0]  s_s  [NSTAGE];
  logic [NSTAGE-1:0] c_s;
  logic [NSTAGE-1:0] v_s;
  logic [WIDTH-1:0]  bx_in_s;
  logic [WIDTH+1:0]  res_s;
  logic              adv_s;

  assign adv_s         = ~v_r[NSTAGE-1] | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = v_r[NSTAGE-1];
  assign bus.sum       = s_r[NSTAGE-1];
  assign bus.carryOut  = c_r[NSTAGE-1];
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;

  // Next-state of every stage: stage 0 from the bus, stage k from stage k-1's registers.
  always_comb begin
    if (bus.sub) begin
      bx_in_s = ~bus.b;
    end else begin
      bx_in_s = bus.b;
    end
    res_s    = group_add(bus.a, bx_in_s, {WIDTH{1'b0}}, bus.carryIn ^ bus.sub, 0);
    a_s[0]   = bus.a;
    bx_s[0]  = bx_in_s;
    s_s[0]   = res_s[WIDTH-1:0];
    c_s      = {NSTAGE{1'b0}};
    v_s      = {NSTAGE{1'b0}};
    c_s[0]   = res_s[WIDTH];
    v_s[0]   = bus.in_valid & adv_s;
    for (int k = 1; k < NSTAGE; k++) begin
      res_s   = group_add(a_r[k-1], bx_r[k-1], s_r[k-1], c_r[k-1], k);
      a_s[k]  = a_r[k-1];
      bx_s[k] = bx_r[k-1];
      s_s[k]  = res_s[WIDTH-1:0];
      c_s[k]  = res_s[WIDTH];
      v_s[k]  = v_r[k-1];
    end
  end

  // Pipeline registers; everything, valid bits included, holds while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        a_r[k]  <= {WIDTH{1'b0}};
        bx_r[k] <= {WIDTH{1'b0}};
        s_r[k]  <= {WIDTH{1'b0}};
      end
      c_r    <= {NSTAGE{1'b0}};
      v_r    <= {NSTAGE{1'b0}};
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < NSTAGE; k++) begin
        a_r[k]  <= a_s[k];
        bx_r[k] <= bx_s[k];
        s_r[k]  <= s_s[k];
      end
      c_r    <= c_s;
      v_r    <= v_s;
      // res_s holds the final group's result after the stage loop
      ovf_r  <= res_s[WIDTH+1];
      zero_r <= ~|s_s[NSTAGE-1];
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub at 16/4, 8/8 and 32/2: latency, flags,
// backpressure streaming and reset with operations in flight.
module tb_pipelined_cla_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub_if #(.WIDTH(16)) if16 ();
  pipelined_cla_addsub_if #(.WIDTH(8))  if8  ();
  pipelined_cla_addsub_if #(.WIDTH(32)) if32 ();

  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  pipelined_cla_addsub #(.WIDTH(8),  .BLOCK(8)) u8  (.clk(clk), .rst(rst), .bus(if8.slave));
  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(2)) u32 (.clk(clk), .rst(rst), .bus(if32.slave));

  // Golden 16-bit model from plain wide addition; returns {sum, carryOut, overflow, zero}.
  function automatic logic [18:0] gold16(input logic [15:0] ga, input logic [15:0] gb,
                                         input logic gcin, input logic gsub);
    logic [15:0] bx;
    logic [16:0] t;
    logic        ov;
    bx = gsub ? ~gb : gb;
    t  = {1'b0, ga} + {1'b0, bx} + {16'd0, gcin ^ gsub};
    ov = (ga[15] == bx[15]) && (t[15] != ga[15]);
    return {t[15:0], t[16], ov, (t[15:0] == 16'd0)};
  endfunction

  // Issues one op on the selected width, then counts edges until out_valid (bounded).
  task automatic issue(input int w, input logic [31:0] ia, input logic [31:0] ib,
                       input logic icin, input logic isub,
                       output logic [31:0] os, output logic oco, output logic oov,
                       output logic oz, output int lat);
    logic vld;
    @(negedge clk);
    case (w)
      8:  begin if8.a = ia[7:0];  if8.b = ib[7:0];  if8.carryIn = icin;  if8.sub = isub;  if8.in_valid = 1'b1;  end
      32: begin if32.a = ia;      if32.b = ib;      if32.carryIn = icin; if32.sub = isub; if32.in_valid = 1'b1; end
      default: begin if16.a = ia[15:0]; if16.b = ib[15:0]; if16.carryIn = icin; if16.sub = isub; if16.in_valid = 1'b1; end
    endcase
    lat = 0;
    vld = 1'b0;
    while (!vld && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if8.in_valid = 1'b0; if16.in_valid = 1'b0; if32.in_valid = 1'b0;
      case (w)
        8:  vld = if8.out_valid;
        32: vld = if32.out_valid;
        default: vld = if16.out_valid;
      endcase
    end
    case (w)
      8:  begin os = {24'd0, if8.sum};  oco = if8.carryOut;  oov = if8.overflow;  oz = if8.zero;  end
      32: begin os = if32.sum;          oco = if32.carryOut; oov = if32.overflow; oz = if32.zero; end
      default: begin os = {16'd0, if16.sum}; oco = if16.carryOut; oov = if16.overflow; oz = if16.zero; end
    endcase
  endtask

  task automatic test_reset();
    #1;
    total += 6;
    if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", if16.out_valid); end
    if (if16.sum !== 16'd0)      begin bad++; $display("FAIL reset_sum got=%h want=0000", if16.sum); end
    if (if16.carryOut !== 1'b0)  begin bad++; $display("FAIL reset_carry got=%b want=0", if16.carryOut); end
    if (if16.overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b want=0", if16.overflow); end
    if (if16.zero !== 1'b0)      begin bad++; $display("FAIL reset_zero got=%b want=0", if16.zero); end
    if (if16.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", if16.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Checks one 16-bit op against hand-computed results at latency 4.
  task automatic test_add16(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                            input logic icin, input logic isub, input logic [18:0] want);
    logic [31:0] s; logic co, ov, z; int lat;
    issue(16, {16'd0, ia}, {16'd0, ib}, icin, isub, s, co, ov, z, lat);
    total += 2;
    if ({s[15:0], co, ov, z} !== want)
      begin bad++; $display("FAIL %s got={%h,%b,%b,%b} want={%h,%b,%b,%b}", nm, s[15:0], co, ov, z, want[18:3], want[2], want[1], want[0]); end
    if (lat !== 4) begin bad++; $display("FAIL %s_latency got=%0d want=4", nm, lat); end
  endtask

  task automatic test_widths();
    logic [31:0] s; logic co, ov, z; int lat;
    logic [31:0] ta [3]; logic [31:0] tb8 [3]; logic tsub [3];
    logic [31:0] ws8 [3]; logic [2:0] wf8 [3];
    logic [31:0] wa32 [3]; logic [31:0] wb32 [3]; logic [31:0] ws32 [3]; logic [2:0] wf32 [3];
    ta   = '{32'h0F, 32'hFF, 32'h7F};  tb8 = '{32'h01, 32'h01, 32'hFF};  tsub = '{1'b0, 1'b0, 1'b1};
    ws8  = '{32'h10, 32'h00, 32'h80};  wf8 = '{3'b000, 3'b101, 3'b010};
    wa32 = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    wb32 = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF};
    ws32 = '{32'h00010000, 32'h00000000, 32'h80000000};
    wf32 = '{3'b000, 3'b101, 3'b010};
    for (int i = 0; i < 3; i++) begin
      issue(8, ta[i], tb8[i], 1'b0, tsub[i], s, co, ov, z, lat);
      total += 2;
      if ({s, co, ov, z} !== {ws8[i], wf8[i]})
        begin bad++; $display("FAIL w8_op%0d got={%h,%b,%b,%b} want={%h,%b}", i, s, co, ov, z, ws8[i], wf8[i]); end
      if (lat !== 1) begin bad++; $display("FAIL w8_latency%0d got=%0d want=1", i, lat); end
      issue(32, wa32[i], wb32[i], 1'b0, tsub[i], s, co, ov, z, lat);
      total += 2;
      if ({s, co, ov, z} !== {ws32[i], wf32[i]})
        begin bad++; $display("FAIL w32_op%0d got={%h,%b,%b,%b} want={%h,%b}", i, s, co, ov, z, ws32[i], wf32[i]); end
      if (lat !== 16) begin bad++; $display("FAIL w32_latency%0d got=%0d want=16", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sa [8]; logic [15:0] sb [8]; logic ssub [8]; logic scin [8];
    logic [18:0] want [8]; logic [18:0] cur; logic [18:0] held_v;
    logic held; int sent; int recv; int stall_seen;
    sa   = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'hABCD, 16'h0000, 16'hF00F};
    sb   = '{16'h4321, 16'h0001, 16'h8000, 16'h0002, 16'h0001, 16'h1234, 16'h0000, 16'h0FF0};
    ssub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    scin = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) want[i] = gold16(sa[i], sb[i], scin[i], ssub[i]);
    sent = 0; recv = 0; stall_seen = 0; held = 1'b0; held_v = 19'd0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      @(negedge clk);
      if16.out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        if16.in_valid = 1'b1; if16.a = sa[sent]; if16.b = sb[sent];
        if16.sub = ssub[sent]; if16.carryIn = scin[sent];
      end else begin
        if16.in_valid = 1'b0;
      end
      #1;
      cur = {if16.sum, if16.carryOut, if16.overflow, if16.zero};
      if (held) begin
        total++;
        if (!if16.out_valid || cur !== held_v)
          begin bad++; $display("FAIL stall_hold got=%h valid=%b want=%h", cur, if16.out_valid, held_v); end
      end
      held = 1'b0;
      if (if16.out_valid && !if16.out_ready) begin
        stall_seen++; total++; held = 1'b1; held_v = cur;
        if (if16.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", if16.in_ready); end
      end
      if (if16.out_valid && if16.out_ready) begin
        total++;
        if (cur !== want[recv]) begin bad++; $display("FAIL stream_result%0d got=%h want=%h", recv, cur, want[recv]); end
        recv++;
      end
      if (if16.in_valid && if16.in_ready) sent++;
    end
    if16.in_valid = 1'b0;
    total += 2;
    if (recv !== 8) begin bad++; $display("FAIL stream_count got=%0d want=8", recv); end
    if (stall_seen !== 3) begin bad++; $display("FAIL stream_stall_cycles got=%0d want=3", stall_seen); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      total++;
      if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL stream_duplicate got=%b want=0", if16.out_valid); end
    end
  endtask

  task automatic test_reset_in_flight();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if16.in_valid = 1'b1; if16.a = 16'h0100 + 16'(i); if16.b = 16'h0011; if16.sub = 1'b0; if16.carryIn = 1'b0;
    end
    @(negedge clk);
    if16.in_valid = 1'b0;
    #1;
    total++;
    if (if16.out_valid !== 1'b1) begin bad++; $display("FAIL flight_pre_valid got=%b want=1", if16.out_valid); end
    rst = 1'b1;
    #1;
    total += 3;
    if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL flight_rst_valid got=%b want=0", if16.out_valid); end
    if ({if16.sum, if16.carryOut, if16.overflow, if16.zero} !== 19'd0)
      begin bad++; $display("FAIL flight_rst_data got=%h want=0", {if16.sum, if16.carryOut, if16.overflow, if16.zero}); end
    if (if16.in_ready !== 1'b1) begin bad++; $display("FAIL flight_rst_in_ready got=%b want=1", if16.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      total++;
      if (if16.out_valid !== 1'b0) begin bad++; $display("FAIL flight_stale got=%b want=0", if16.out_valid); end
    end
    test_add16("after_reset", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, {16'h1000, 3'b000});
  endtask

  initial begin
    if16.in_valid = 1'b0; if16.a = 16'd0; if16.b = 16'd0; if16.carryIn = 1'b0; if16.sub = 1'b0; if16.out_ready = 1'b1;
    if8.in_valid  = 1'b0; if8.a  = 8'd0;  if8.b  = 8'd0;  if8.carryIn  = 1'b0; if8.sub  = 1'b0; if8.out_ready  = 1'b1;
    if32.in_valid = 1'b0; if32.a = 32'd0; if32.b = 32'd0; if32.carryIn = 1'b0; if32.sub = 1'b0; if32.out_ready = 1'b1;
    test_reset();
    test_add16("add_basic",   16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 3'b000});
    test_add16("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 3'b101});
    test_add16("sub_ovf",     16'h7FFF, 16'hFFFF, 1'b0, 1'b1, {16'h8000, 3'b010});
    test_add16("sub_equal",   16'h0005, 16'h0005, 1'b0, 1'b1, {16'h0000, 3'b101});
    test_add16("sub_borrow",  16'h0005, 16'h0003, 1'b1, 1'b1, {16'h0001, 3'b100});
    test_add16("add_cin",     16'h1234, 16'h1111, 1'b1, 1'b0, {16'h2346, 3'b000});
    test_widths();
    test_back_to_back();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Operand width is split into BLOCK-bit lookahead groups. Each group resolves in its own pipeline stage, with the carry registered between groups.
- Valid/ready handshake on both sides, full backpressure, one result per cycle sustained.
- Datapath arithmetic primitive for the ALU; successor to the fixed 4-bit combinational CLA.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of BLOCK.
- BLOCK, 4, bits per lookahead group (1..8). Carry within a group uses full lookahead expansion, not ripple.
- NSTAGE, WIDTH/BLOCK, derived (localparam). Number of pipeline stages, which equals latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carryIn  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 = A+B+carryIn; 1 = A-B-carryIn.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carryOut  out  1  raw carry out of MSB group.
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Effective operands:
  - Bx = sub ? ~b : b.
  - c0 = carryIn ^ sub.
  - Result = A + Bx + c0 mod 2^WIDTH.
  - Subtract: carryOut=1 means no borrow.
- Per group g (bits g*BLOCK .. g*BLOCK+BLOCK-1):
  - P = A ^ Bx, G = A & Bx.
  - Group carries computed by lookahead from the registered group carry-in.
  - sum slice = P ^ carries.
- Pipeline:
  - Stage 1 register captures group 0 result, the carry into group 1, and the unprocessed upper operand slices (Bx already inverted) plus valid.
  - Stage k computes group k-1 from stage k-1 contents.
  - Stage NSTAGE holds the complete result, driving sum/carryOut/overflow/zero/out_valid directly from registers.
- Latency: a transfer accepted on edge n appears with out_valid=1 after edge n+NSTAGE-1, i.e. NSTAGE cycles from the in_valid&in_ready cycle to the first out_valid cycle with no stall.
- Flags:
  - overflow = carry into MSB ^ carry out of MSB.
  - zero = ~|sum.
  - All flags registered alongside sum in the final stage.
- Handshake:
  - Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational, no dependence on in_valid).
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - On adv=0 every stage, including valid bits, holds.
  - On adv=1 every stage shifts; stage 1 loads in_valid&in_ready and the operand-derived data.
  - Bubbles propagate as valid=0 stages.
  - Output data is stable while out_valid=1 and out_ready=0.
- Throughput: one op per cycle when out_ready held high. Back-to-back ops never interact; carry state is per-stage.
- Reset (async assert, release synchronous to clk):
  - All stage valid bits = 0, out_valid = 0.
  - sum = 0, carryOut = 0, overflow = 0, zero = 0.
  - in_ready = 1 after reset since out_valid = 0.
  - Reset mid-operation discards all in-flight ops; no partial result is emitted.
- Boundaries:
  - WIDTH=BLOCK gives NSTAGE=1: a single registered CLA, latency 1.
  - in_valid with in_ready=0: operands are not captured and upstream must hold them.
  - Simultaneous output pop and input push: both occur.
- Elaboration error if WIDTH % BLOCK != 0 or BLOCK outside 1..8.

Test Plan:
- WIDTH=16, BLOCK=4, out_ready=1: a=0x00FF, b=0x0001, sub=0, carryIn=0 -> 4 cycles later sum=0x0100, carryOut=0, overflow=0, zero=0.
- a=0xFFFF, b=0x0001, carryIn=0 -> sum=0x0000, carryOut=1, zero=1, overflow=0. This tests full carry chain across all 4 stages.
- sub=1, a=0x7FFF, b=0xFFFF, carryIn=0 -> sum=0x8000, overflow=1, carryOut=0. Also sub=1, a=5, b=5 -> sum=0, zero=1, carryOut=1.
- Stream 8 random ops back-to-back, out_ready low for 3 cycles mid-stream:
  - in_ready drops while out_valid=1 and out_ready=0; the held output is stable.
  - All 8 results arrive in order and match the golden model; no loss or duplication.
- Assert rst with 3 ops in flight -> out_valid=0 and flags/sum=0 immediately; no stale result after release; the next op returns correctly at latency 4.
- Rerun the first three scenarios with WIDTH=8, BLOCK=8 (latency 1) and WIDTH=32, BLOCK=2 (latency 16), results checked against the reference model.
